// File: rtl/pkt_disassembler.sv
// Multicast packet disassembler: checks parity and type, emits keys (and payload when
// PKT_DIS_PLD_EN is defined) as event words, and keeps saturating drop/accept counters.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module pkt_disassembler #(
    parameter int PACKET_BITS = `PKT_BITS,
    parameter int CNT_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] pkt_data_in,
    input  logic                   pkt_vld_in,
    output logic                   pkt_rdy_out,
    output logic [31:0]            evt_data_out,
    output logic                   evt_pld_out,
    output logic                   evt_vld_out,
    input  logic                   evt_rdy_in,
    input  logic                   clr_cnt_in,
    output logic [CNT_BITS-1:0]    pkt_cnt_out,
    output logic [CNT_BITS-1:0]    err_cnt_out,
    output logic [CNT_BITS-1:0]    drp_cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_live;
    logic                r_evt_vld;
    logic                r_evt_pld;
    logic [31:0]         r_evt_data;
    logic [CNT_BITS-1:0] r_pkt_cnt;
    logic [CNT_BITS-1:0] r_err_cnt;
    logic [CNT_BITS-1:0] r_drp_cnt;

    logic [7:0]          w_hdr;
    logic [31:0]         w_key;
    logic                w_par_ok;
    logic                w_is_mc;
    logic                w_pkt_xfer;
    logic                w_good;
    logic                w_bad_par;
    logic                w_not_mc;
    logic                w_evt_xfer;
    logic                w_final;
    logic                w_more;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return v + {{(CNT_BITS-1){1'b0}}, ~&v};
    endfunction

    assign w_hdr    = pkt_data_in[7:0];
    assign w_key    = pkt_data_in[39:8];
    // Odd parity spans the payload only when the header says one is present.
    assign w_par_ok = w_hdr[1] ? (^pkt_data_in[PACKET_BITS-1:0]) : (^pkt_data_in[39:0]);
    assign w_is_mc  = (w_hdr[7:6] == 2'b00);

    assign w_pkt_xfer = pkt_vld_in && pkt_rdy_out;
    assign w_bad_par  = w_pkt_xfer && !w_par_ok;
    assign w_not_mc   = w_pkt_xfer && w_par_ok && !w_is_mc;
    assign w_good     = w_pkt_xfer && w_par_ok && w_is_mc;

    assign w_evt_xfer = r_evt_vld && evt_rdy_in;

`ifdef PKT_DIS_PLD_EN
    logic        r_has_pld;
    logic [31:0] r_pld;

    assign w_more  = (r_state == KEY) && r_has_pld;
    assign w_final = w_evt_xfer && (r_state == PLD || (r_state == KEY && !r_has_pld));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_has_pld <= 1'b0;
            r_pld     <= '0;
        end else if (w_good) begin
            r_has_pld <= w_hdr[1];
            r_pld     <= pkt_data_in[PACKET_BITS-1:40];
        end
    end
`else
    assign w_more  = 1'b0;
    assign w_final = w_evt_xfer && (r_state == KEY);
`endif

    // Ready is held low until the first edge after reset releases.
    assign pkt_rdy_out = r_live && ((r_state == IDLE) || w_final);

    assign evt_vld_out  = r_evt_vld;
    assign evt_pld_out  = r_evt_pld;
    assign evt_data_out = r_evt_data;
    assign pkt_cnt_out  = r_pkt_cnt;
    assign err_cnt_out  = r_err_cnt;
    assign drp_cnt_out  = r_drp_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_evt_vld  <= 1'b0;
            r_evt_pld  <= 1'b0;
            r_evt_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_good) begin
                        r_state    <= KEY;
                        r_evt_vld  <= 1'b1;
                        r_evt_pld  <= 1'b0;
                        r_evt_data <= w_key;
                    end
                end
                KEY, PLD: begin
                    if (w_evt_xfer) begin
`ifdef PKT_DIS_PLD_EN
                        if (w_more) begin
                            r_state    <= PLD;
                            r_evt_pld  <= 1'b1;
                            r_evt_data <= r_pld;
                        end else
`endif
                        // Final word released: a packet taken on this edge goes straight to KEY.
                        if (w_good) begin
                            r_state    <= KEY;
                            r_evt_vld  <= 1'b1;
                            r_evt_pld  <= 1'b0;
                            r_evt_data <= w_key;
                        end else begin
                            r_state    <= IDLE;
                            r_evt_vld  <= 1'b0;
                            r_evt_pld  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_evt_vld <= 1'b0;
                    r_evt_pld <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            r_drp_cnt <= '0;
        end else if (clr_cnt_in) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            r_drp_cnt <= '0;
        end else begin
            if (w_good)    r_pkt_cnt <= sat_inc(r_pkt_cnt);
            if (w_bad_par) r_err_cnt <= sat_inc(r_err_cnt);
            if (w_not_mc)  r_drp_cnt <= sat_inc(r_drp_cnt);
        end
    end

endmodule
